// File: rtl/bcd_serial_add_ctrl_pkg.sv
// Shared calculator types: FSM state encoding, BCD digit type and digit validity helper.
package bcd_calc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PASS1 = 2'd1,
        PASS2 = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef logic [3:0] digit_t;

    localparam digit_t BCD_MAX = 4'd9;

    function automatic logic digit_invalid(input digit_t d);
        return d > BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_serial_add_ctrl_if.sv
// Start/done handshake and operand/result bus between calculator control and the serial BCD adder.
interface bcd_serial_add_ctrl_if #(
    parameter int unsigned DIGITS = 4
);
    logic                  start;
    logic [4*DIGITS-1:0]   a_bcd;
    logic [4*DIGITS-1:0]   b_bcd;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   sum_bcd;
    logic                  carry_out;
    logic                  error;

    modport master (
        output start, a_bcd, b_bcd,
        input  busy, done, sum_bcd, carry_out, error
    );

    modport slave (
        input  start, a_bcd, b_bcd,
        output busy, done, sum_bcd, carry_out, error
    );
endinterface

// File: rtl/bcd_serial_add_ctrl_adder.sv
// Single-digit BCD adder without carry input; shared by both passes of the serial sequencer.
module bcd_adder_4bit
    import bcd_calc_pkg::*;
(
    input  digit_t a,
    input  digit_t b,
    output digit_t sum,
    output logic   carry_out
);
    logic [4:0] raw;

    always_comb begin
        raw       = {1'b0, a} + {1'b0, b};
        carry_out = raw > 5'd9;
        sum       = carry_out ? 4'(raw + 5'd6) : raw[3:0];
    end
endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial BCD adder sequencer, two adder passes per digit, LSD first.
// Optional input nibble validation under `BCD_INPUT_CHECK_EN.
module bcd_serial_add_ctrl
    import bcd_calc_pkg::*;
#(
    parameter int unsigned DIGITS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bcd_serial_add_ctrl_if.slave bus
);
    localparam int unsigned W     = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(DIGITS);

    state_e             state_q, state_d;
    logic [W-1:0]       a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    digit_t             p_q, p_d;
    logic               c1_q, c1_d, carry_q, carry_d;
    logic               carry_out_q, carry_out_d;
    logic               busy_q, busy_d, done_q, done_d;

    digit_t             add_a, add_b, add_sum;
    logic               add_co;

    bcd_adder_4bit u_adder (
        .a         (add_a),
        .b         (add_b),
        .sum       (add_sum),
        .carry_out (add_co)
    );

`ifdef BCD_INPUT_CHECK_EN
    logic error_q, error_d, bad_c;

    always_comb begin
        bad_c = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            bad_c = bad_c | digit_invalid(bus.a_bcd[4*i +: 4])
                          | digit_invalid(bus.b_bcd[4*i +: 4]);
        end
    end

    assign bus.error = error_q;
`else
    assign bus.error = 1'b0;
`endif

    // Operand mux: PASS1 adds the operand digits, PASS2 injects the pending carry.
    always_comb begin
        if (state_q == PASS1) begin
            add_a = a_q[3:0];
            add_b = b_q[3:0];
        end else begin
            add_a = p_q;
            add_b = {3'b000, carry_q};
        end
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        cnt_d       = cnt_q;
        p_d         = p_q;
        c1_d        = c1_q;
        carry_d     = carry_q;
        carry_out_d = carry_out_q;
`ifdef BCD_INPUT_CHECK_EN
        error_d     = error_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d         = bus.a_bcd;
                    b_d         = bus.b_bcd;
                    sum_d       = '0;
                    cnt_d       = '0;
                    carry_d     = 1'b0;
                    carry_out_d = 1'b0;
                    state_d     = PASS1;
`ifdef BCD_INPUT_CHECK_EN
                    error_d     = bad_c;
`endif
                end
            end
            PASS1: begin
                p_d     = add_sum;
                c1_d    = add_co;
                state_d = PASS2;
`ifdef BCD_INPUT_CHECK_EN
                if (error_q) begin
                    state_d = DONE;
                end
`endif
            end
            PASS2: begin
                sum_d   = {add_sum, sum_q[W-1:4]};
                carry_d = c1_q | add_co;
                a_d     = a_q >> 4;
                b_d     = b_q >> 4;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(DIGITS - 1)) begin
                    carry_out_d = carry_d;
                    state_d     = DONE;
                end else begin
                    state_d = PASS1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = state_d != IDLE;
        done_d = state_d == DONE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            cnt_q       <= '0;
            p_q         <= '0;
            c1_q        <= 1'b0;
            carry_q     <= 1'b0;
            carry_out_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef BCD_INPUT_CHECK_EN
            error_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            cnt_q       <= cnt_d;
            p_q         <= p_d;
            c1_q        <= c1_d;
            carry_q     <= carry_d;
            carry_out_q <= carry_out_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef BCD_INPUT_CHECK_EN
            error_q     <= error_d;
`endif
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.sum_bcd   = sum_q;
    assign bus.carry_out = carry_out_q;
endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Self-checking bench for bcd_serial_add_ctrl: directed cases plus random operands vs a decimal model.
module tb_bcd_serial_add_ctrl;
    localparam int unsigned DIGITS = 4;
    localparam int unsigned W      = 4 * DIGITS;
    localparam int unsigned LAT    = 2 * DIGITS + 1;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    bcd_serial_add_ctrl_if #(.DIGITS(DIGITS)) bus ();

    bcd_serial_add_ctrl #(.DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int unsigned bcd_to_int(input logic [W-1:0] x);
        int unsigned r = 0;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) r = r * 10 + int'(x[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [W-1:0] int_to_bcd(input int unsigned v);
        logic [W-1:0] r = '0;
        int unsigned  t = v;
        for (int i = 0; i < int'(DIGITS); i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic [W-1:0] rand_bcd();
        logic [W-1:0] r;
        for (int i = 0; i < int'(DIGITS); i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
        return r;
    endfunction

    // Called at a negedge in IDLE; returns at the negedge of the first idle cycle after done.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit inj, input bit chk_sum, input int exp_lat, input bit exp_err);
        int unsigned  lim, s;
        logic [W-1:0] exp_sum;
        logic         exp_co;
        int           lat;
        lim     = 1;
        for (int i = 0; i < int'(DIGITS); i++) lim = lim * 10;
        s       = bcd_to_int(a) + bcd_to_int(b);
        exp_co  = s >= lim;
        exp_sum = int_to_bcd(s % lim);
        if (exp_err) begin
            exp_sum = '0;
            exp_co  = 1'b0;
        end
        bus.a_bcd = a;
        bus.b_bcd = b;
        bus.start = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        bus.a_bcd = W'($urandom);
        bus.b_bcd = W'($urandom);
        check_eq({tag, "_busy"}, 32'(bus.busy), 32'd1);
        while (!bus.done && lat < 30) begin
            bus.start = inj && (lat == 3);
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check_eq({tag, "_err"}, 32'(bus.error), 32'(exp_err));
        if (chk_sum) begin
            check_eq({tag, "_sum"}, 32'(bus.sum_bcd), 32'(exp_sum));
            check_eq({tag, "_co"}, 32'(bus.carry_out), 32'(exp_co));
        end
        check_eq({tag, "_busy_done"}, 32'(bus.busy), 32'd1);
        bus.start = inj;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        check_eq({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
        check_eq({tag, "_idle"}, 32'(bus.busy), 32'd0);
        if (chk_sum) check_eq({tag, "_hold"}, 32'(bus.sum_bcd), 32'(exp_sum));
    endtask

    task automatic reset_mid_op();
        bit seen_done = 1'b0;
        int lat;
        bus.a_bcd = 16'h4321;
        bus.b_bcd = 16'h1111;
        bus.start = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        bus.start = 1'b0;
        while (lat < 5) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_eq("rst_mid_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_mid_sum", 32'(bus.sum_bcd), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            seen_done = seen_done | bus.done;
            @(posedge clk);
            @(negedge clk);
        end
        check_eq("rst_mid_no_done", 32'(seen_done), 32'd0);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.a_bcd = '0;
        bus.b_bcd = '0;
        rst_n     = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_done", 32'(bus.done), 32'd0);
        check_eq("rst_sum", 32'(bus.sum_bcd), 32'd0);
        check_eq("rst_co", 32'(bus.carry_out), 32'd0);
        check_eq("rst_err", 32'(bus.error), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("d1234_5678", 16'h1234, 16'h5678, 1'b0, 1'b1, LAT, 1'b0);
        run_op("d9999_0001", 16'h9999, 16'h0001, 1'b0, 1'b1, LAT, 1'b0);
        run_op("d0999_0001", 16'h0999, 16'h0001, 1'b0, 1'b1, LAT, 1'b0);
        run_op("d0000_0000", 16'h0000, 16'h0000, 1'b0, 1'b1, LAT, 1'b0);
        run_op("inj_start", 16'h2468, 16'h1357, 1'b1, 1'b1, LAT, 1'b0);
`ifdef BCD_INPUT_CHECK_EN
        run_op("bad_nibble", 16'h12A4, 16'h0001, 1'b0, 1'b1, 2, 1'b1);
`else
        run_op("bad_nibble", 16'h12A4, 16'h0001, 1'b0, 1'b0, LAT, 1'b0);
`endif
        reset_mid_op();
        run_op("after_rst", 16'h8765, 16'h4321, 1'b0, 1'b1, LAT, 1'b0);

        for (int n = 0; n < 25; n++) begin
            run_op($sformatf("rnd%0d", n), rand_bcd(), rand_bcd(),
                   1'($urandom_range(0, 3) == 0), 1'b1, LAT, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
